alu_share_arbiter: RTL and testbench

- Shares one registered 8-bit ALU (ADD/SUB/LSL/LSR, 2-bit opcode, 1-cycle registered output) between NUM_REQ requesters.
- Arbitrates round-robin and launches the winning operation onto the ALU input ports.
- Captures the ALU output and returns it, tagged with the requester ID, over a valid/ready response channel.
- Sits between client blocks and the ALU instance; the ALU is instantiated outside and wired to the oALU_*/iALU_* ports.

---
 rtl/alu_share_arbiter.sv | 129 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin front end that shares one registered ALU between NUM_REQ clients.
// Exactly one operation is outstanding at a time, so responses come back in grant order.
module alu_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int ID_W    = 2
) (
   input  logic                      iCLK,
   input  logic                      iRST,
   input  logic [NUM_REQ-1:0]        iREQ_VALID,
   output logic [NUM_REQ-1:0]        oREQ_READY,
   input  logic [2*NUM_REQ-1:0]      iREQ_OPCODE,
   input  logic [DATA_W*NUM_REQ-1:0] iREQ_DATA1,
   input  logic [DATA_W*NUM_REQ-1:0] iREQ_DATA2,
   output logic [1:0]                oALU_OPCODE,
   output logic [DATA_W-1:0]         oALU_DATAIN1,
   output logic [DATA_W-1:0]         oALU_DATAIN2,
   input  logic [DATA_W-1:0]         iALU_DATAOUT,
   output logic                      oRSP_VALID,
   output logic [ID_W-1:0]           oRSP_ID,
   output logic [DATA_W-1:0]         oRSP_DATA,
   input  logic                      iRSP_READY,
   output logic                      oBUSY
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t            state;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   owner_id;
   logic [ID_W-1:0]   grant_idx;
   logic [ID_W-1:0]   cand_idx;
   logic [ID_W-1:0]   next_ptr;
   logic              grant_found;
   int                cand;
   logic [1:0]        grant_op;
   logic [DATA_W-1:0] grant_data1;
   logic [DATA_W-1:0] grant_data2;

   // Search upward from the pointer with wrap; the first valid requester wins.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      cand_idx    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = int'(rr_ptr) + i;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         cand_idx = cand[ID_W-1:0];
         if (!grant_found && iREQ_VALID[cand_idx]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx;
         end
      end
   end

   always_comb begin
      grant_op    = iREQ_OPCODE[2*grant_idx +: 2];
      grant_data1 = iREQ_DATA1[DATA_W*grant_idx +: DATA_W];
      grant_data2 = iREQ_DATA2[DATA_W*grant_idx +: DATA_W];
      next_ptr    = (int'(grant_idx) == NUM_REQ-1) ? '0 : grant_idx + 1'b1;
   end

   // Ready is only offered from IDLE and never while reset is asserted.
   always_comb begin
      oREQ_READY = '0;
      if (state == S_IDLE && !iRST && grant_found) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            oREQ_READY[k] = (grant_idx == ID_W'(k));
         end
      end
   end

   assign oBUSY = (state != S_IDLE);

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state        <= S_IDLE;
         rr_ptr       <= '0;
         owner_id     <= '0;
         oALU_OPCODE  <= '0;
         oALU_DATAIN1 <= '0;
         oALU_DATAIN2 <= '0;
         oRSP_VALID   <= 1'b0;
         oRSP_ID      <= '0;
         oRSP_DATA    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant_found) begin
                  oALU_OPCODE  <= grant_op;
                  oALU_DATAIN1 <= grant_data1;
                  oALU_DATAIN2 <= grant_data2;
                  owner_id     <= grant_idx;
                  rr_ptr       <= next_ptr;
                  state        <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               state <= S_WAIT;
            end
            // The ALU registered its result at the end of ISSUE, so it is ready here.
            S_WAIT: begin
               oRSP_DATA  <= iALU_DATAOUT;
               oRSP_ID    <= owner_id;
               oRSP_VALID <= 1'b1;
               state      <= S_RESP;
            end
            S_RESP: begin
               if (iRSP_READY) begin
                  oRSP_VALID <= 1'b0;
                  state      <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural registered ALU attached.
module tb_alu_share_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 8;
   localparam int ID_W    = 2;

   logic                      clk;
   logic                      rst;
   logic [NUM_REQ-1:0]        reqValidBus;
   logic [NUM_REQ-1:0]        reqReady;
   logic [2*NUM_REQ-1:0]      reqOpcodeBus;
   logic [DATA_W*NUM_REQ-1:0] reqData1Bus;
   logic [DATA_W*NUM_REQ-1:0] reqData2Bus;
   logic [1:0]                aluOpcode;
   logic [DATA_W-1:0]         aluIn1;
   logic [DATA_W-1:0]         aluIn2;
   logic [DATA_W-1:0]         aluOut;
   logic                      rspValid;
   logic [ID_W-1:0]           rspId;
   logic [DATA_W-1:0]         rspData;
   logic                      rspReady;
   logic                      busy;

   typedef struct {
      int         id;
      logic [7:0] data;
      int         cyc;
   } sbEntry_t;

   logic [3:0] reqValid;
   logic [1:0] reqOp [4];
   logic [7:0] reqA [4];
   logic [7:0] reqB [4];
   bit         reissue;
   sbEntry_t   sb [$];
   int         grantId [$];
   int         grantCyc [$];
   int         cycle;
   int         checkCount;
   int         passCount;
   logic [3:0] lastReady;
   logic       prevRspValid;

   alu_share_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
      .iCLK         (clk),
      .iRST         (rst),
      .iREQ_VALID   (reqValidBus),
      .oREQ_READY   (reqReady),
      .iREQ_OPCODE  (reqOpcodeBus),
      .iREQ_DATA1   (reqData1Bus),
      .iREQ_DATA2   (reqData2Bus),
      .oALU_OPCODE  (aluOpcode),
      .oALU_DATAIN1 (aluIn1),
      .oALU_DATAIN2 (aluIn2),
      .iALU_DATAOUT (aluOut),
      .oRSP_VALID   (rspValid),
      .oRSP_ID      (rspId),
      .oRSP_DATA    (rspData),
      .iRSP_READY   (rspReady),
      .oBUSY        (busy)
   );

   function automatic logic [7:0] aluRef(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         2'b00:   return a + b;
         2'b01:   return a - b;
         2'b10:   return {a[6:0], 1'b0};
         default: return {1'b0, a[7:1]};
      endcase
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      aluOut <= aluRef(aluOpcode, aluIn1, aluIn2);
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
      end else begin
         passCount++;
      end
   endtask

   task automatic driveInputs();
      for (int k = 0; k < NUM_REQ; k++) begin
         reqValidBus[k]              = reqValid[k];
         reqOpcodeBus[2*k +: 2]      = reqOp[k];
         reqData1Bus[DATA_W*k +: 8]  = reqA[k];
         reqData2Bus[DATA_W*k +: 8]  = reqB[k];
      end
   endtask

   task automatic setRequest(input int k, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      reqValid[k] = 1'b1;
      reqOp[k]    = op;
      reqA[k]     = a;
      reqB[k]     = b;
      driveInputs();
   endtask

   // One clock: observe handshakes on the falling edge, then update requesters after the rising edge.
   task automatic applyStimulus();
      logic [3:0] hs;
      sbEntry_t   e;
      @(negedge clk);
      lastReady = reqReady;
      hs = reqReady & reqValid;
      if (reqValid != 4'b0000) begin
         checkOutput("ready_onehot", 32'($countones(reqReady) <= 1), 32'd1);
      end
      for (int k = 0; k < NUM_REQ; k++) begin
         if (hs[k]) begin
            sb.push_back('{id: k, data: aluRef(reqOp[k], reqA[k], reqB[k]), cyc: cycle});
            grantId.push_back(k);
            grantCyc.push_back(cycle);
         end
      end
      if (rspValid && !prevRspValid) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            checkOutput("rsp_latency", 32'(cycle - sb[0].cyc), 32'd3);
         end
      end
      prevRspValid = rspValid;
      if (rspValid && rspReady && sb.size() > 0) begin
         e = sb.pop_front();
         checkOutput("rsp_id", 32'(rspId), 32'(e.id));
         checkOutput("rsp_data", 32'(rspData), 32'(e.data));
      end
      @(posedge clk);
      #1;
      cycle++;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (hs[k]) begin
            if (reissue) begin
               reqOp[k] = 2'($urandom_range(0, 3));
               reqA[k]  = 8'($urandom);
               reqB[k]  = 8'($urandom);
            end else begin
               reqValid[k] = 1'b0;
            end
         end
      end
      driveInputs();
   endtask

   task automatic drainAll();
      int n;
      n = 0;
      while ((sb.size() != 0 || reqValid != 4'b0000 || busy) && n < 60) begin
         applyStimulus();
         n++;
      end
      if (n >= 60) begin
         checkOutput("drain_timeout", 32'd0, 32'd1);
      end
   endtask

   task automatic applyReset();
      rst = 1'b1;
      #1;
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      prevRspValid = 1'b0;
   endtask

   initial begin
      int start;
      int expOrder [5];
      int n;
      expOrder = '{0, 1, 2, 3, 0};
      cycle = 0;
      checkCount = 0;
      passCount = 0;
      reissue = 1'b0;
      prevRspValid = 1'b0;
      lastReady = '0;
      rspReady = 1'b1;
      for (int k = 0; k < NUM_REQ; k++) begin
         reqOp[k] = 2'b00;
         reqA[k]  = 8'h00;
         reqB[k]  = 8'h00;
      end
      reqValid = 4'b1111;
      driveInputs();

      // Reset state with every requester asking.
      rst = 1'b1;
      #1;
      checkOutput("reset_ready", 32'(reqReady), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_rsp_valid", 32'(rspValid), 32'd0);
      checkOutput("reset_rsp_id", 32'(rspId), 32'd0);
      checkOutput("reset_rsp_data", 32'(rspData), 32'd0);
      checkOutput("reset_alu_op", 32'(aluOpcode), 32'd0);
      checkOutput("reset_alu_d1", 32'(aluIn1), 32'd0);
      checkOutput("reset_alu_d2", 32'(aluIn2), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reqValid = 4'b0000;
      driveInputs();
      rst = 1'b0;

      // Single ADD from requester 0.
      setRequest(0, 2'b00, 8'h12, 8'h34);
      applyStimulus();
      checkOutput("add_ready", 32'(lastReady), 32'b0001);
      checkOutput("add_busy_e1", 32'(busy), 32'd1);
      applyStimulus();
      checkOutput("add_busy_e2", 32'(busy), 32'd1);
      applyStimulus();
      checkOutput("add_busy_e3", 32'(busy), 32'd1);
      checkOutput("add_rsp_valid", 32'(rspValid), 32'd1);
      applyStimulus();
      checkOutput("add_busy_done", 32'(busy), 32'd0);
      checkOutput("add_sb_empty", 32'(sb.size()), 32'd0);

      // SUB wrap and both shifts.
      setRequest(2, 2'b01, 8'h05, 8'h07);
      drainAll();
      setRequest(1, 2'b10, 8'h81, 8'h00);
      drainAll();
      setRequest(3, 2'b11, 8'h81, 8'h00);
      drainAll();

      // Pointer wrap: after granting 3, requester 0 beats requester 2.
      setRequest(3, 2'b00, 8'h01, 8'h02);
      drainAll();
      start = grantId.size();
      setRequest(0, 2'b00, 8'hFF, 8'h01);
      setRequest(2, 2'b01, 8'h00, 8'h01);
      drainAll();
      if (grantId.size() >= start + 2) begin
         checkOutput("wrap_first", 32'(grantId[start]), 32'd0);
         checkOutput("wrap_second", 32'(grantId[start+1]), 32'd2);
      end else begin
         checkOutput("wrap_grants", 32'(grantId.size() - start), 32'd2);
      end

      // Round-robin fairness from a freshly reset pointer.
      applyReset();
      start = grantId.size();
      reissue = 1'b1;
      for (int k = 0; k < NUM_REQ; k++) begin
         setRequest(k, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      end
      n = 0;
      while (grantId.size() < start + 5 && n < 100) begin
         applyStimulus();
         n++;
      end
      reissue = 1'b0;
      reqValid = 4'b0000;
      driveInputs();
      drainAll();
      if (grantId.size() >= start + 5) begin
         for (int i = 0; i < 5; i++) begin
            checkOutput("rr_order", 32'(grantId[start+i]), 32'(expOrder[i]));
            if (i > 0) begin
               checkOutput("rr_interval", 32'(grantCyc[start+i] - grantCyc[start+i-1]), 32'd4);
            end
         end
      end else begin
         checkOutput("rr_timeout", 32'(grantId.size() - start), 32'd5);
      end

      // Backpressure holds the response and blocks new grants.
      rspReady = 1'b0;
      setRequest(0, 2'b00, 8'hF0, 8'h20);
      applyStimulus();
      setRequest(1, 2'b01, 8'h10, 8'h01);
      n = 0;
      while (!rspValid && n < 10) begin
         applyStimulus();
         n++;
      end
      checkOutput("bp_rsp_arrived", 32'(rspValid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus();
         checkOutput("bp_valid", 32'(rspValid), 32'd1);
         checkOutput("bp_id", 32'(rspId), 32'd0);
         checkOutput("bp_data", 32'(rspData), 32'h10);
         checkOutput("bp_ready", 32'(lastReady), 32'd0);
      end
      rspReady = 1'b1;
      applyStimulus();
      applyStimulus();
      checkOutput("bp_resume_ready", 32'(lastReady), 32'b0010);
      drainAll();

      // Reset during WAIT discards the operation.
      setRequest(1, 2'b00, 8'h11, 8'h22);
      applyStimulus();
      applyStimulus();
      rst = 1'b1;
      reqValid = 4'b0100;
      driveInputs();
      #1;
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_ready", 32'(reqReady), 32'd0);
      checkOutput("midrst_rsp_valid", 32'(rspValid), 32'd0);
      checkOutput("midrst_rsp_id", 32'(rspId), 32'd0);
      checkOutput("midrst_rsp_data", 32'(rspData), 32'd0);
      checkOutput("midrst_alu_d1", 32'(aluIn1), 32'd0);
      checkOutput("midrst_alu_d2", 32'(aluIn2), 32'd0);
      sb.delete();
      prevRspValid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reqValid = 4'b0000;
      driveInputs();
      rst = 1'b0;
      repeat (6) applyStimulus();
      checkOutput("midrst_no_rsp", 32'(rspValid), 32'd0);
      start = grantId.size();
      setRequest(1, 2'b00, 8'h01, 8'h01);
      drainAll();
      checkOutput("midrst_regrant", 32'(grantId.size() - start), 32'd1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
